// File: rtl/cfg_logic_cluster.sv
// rtl/cfg_logic_cluster.sv - cluster of K-input LUT logic elements configured through a serial scan chain
// Outputs are held at 0 until a complete frame has been shifted in and the load has closed.
module cfg_logic_cluster #(
  parameter int K      = 5,
  parameter int NUM_LE = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cfg_en,
  input  logic                  cfg_in,
  output logic                  cfg_out,
  input  logic                  ce,
  input  logic [NUM_LE*K-1:0]   le_in,
  output logic [NUM_LE-1:0]     le_out,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int T        = 2 ** K;
  localparam int F        = T + 1;
  localparam int CFG_BITS = NUM_LE * F;
  localparam int CW       = $clog2(CFG_BITS + 1);

  typedef enum logic [1:0] {
    UNCONF  = 2'd0,
    LOADING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t                state;
  logic [CW-1:0]         count;
  logic [CFG_BITS-1:0]   chain;

  // New bits enter at the top, so the first bit shifted lands in chain[0].
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else if (cfg_en) begin
      chain <= {cfg_in, chain[CFG_BITS-1:1]};
    end
  end

  assign cfg_out = chain[0];

  // cfg_done is a registered copy of (state == ACTIVE).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= UNCONF;
      count    <= '0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else if (cfg_en) begin
      state    <= LOADING;
      cfg_done <= 1'b0;
      if (state != LOADING) begin
        count <= CW'(1);
      end else if (count != CW'(CFG_BITS)) begin
        count <= count + CW'(1);
      end
    end else if (state == LOADING) begin
      if (count == CW'(CFG_BITS)) begin
        state    <= ACTIVE;
        cfg_done <= 1'b1;
        cfg_err  <= 1'b0;
      end else begin
        state    <= UNCONF;
        cfg_err  <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_LE; i++) begin : g_le
    logic [T-1:0] table_bits;
    logic         lut;
    logic         sel;
    logic         q;

    assign table_bits = chain[i*F +: T];
    assign lut        = table_bits[le_in[i*K +: K]];
    assign sel        = chain[i*F + T];

    // q survives reconfiguration so a registered LE resumes its old value.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        q <= 1'b0;
      end else if (cfg_done && ce) begin
        q <= lut;
      end
    end

    assign le_out[i] = cfg_done & (sel ? q : lut);
  end

endmodule

// File: tb/tb_cfg_logic_cluster.sv
// tb/tb_cfg_logic_cluster.sv - directed self-checking bench for cfg_logic_cluster (K=5, NUM_LE=2)
module tb_cfg_logic_cluster;

  logic       clock;
  logic       reset_n;
  logic       cfg_en;
  logic       cfg_in;
  logic       cfg_out;
  logic       ce;
  logic [9:0] le_in;
  logic [1:0] le_out;
  logic       cfg_done;
  logic       cfg_err;

  int errors;
  int checks;

  logic [65:0] frame;
  logic [69:0] fv;
  logic [69:0] ovr;

  cfg_logic_cluster #(.K(5), .NUM_LE(2)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .cfg_en   (cfg_en),
    .cfg_in   (cfg_in),
    .cfg_out  (cfg_out),
    .ce       (ce),
    .le_in    (le_in),
    .le_out   (le_out),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic shift_bits(input logic [69:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      cfg_en = 1'b1;
      cfg_in = v[i];
      tick();
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    frame   = {1'b1, 32'h80000000, 1'b0, 32'h96696996};
    fv      = {4'b0000, frame};
    ovr     = {frame, 4'b1101};
    reset_n = 1'b0;
    cfg_en  = 1'b0;
    cfg_in  = 1'b0;
    ce      = 1'b0;
    le_in   = '0;
    tick();
    tick();

    // 1: reset state and le_in sweep while unconfigured
    chk("rst_le_out", 32'(le_out), 32'h0);
    chk("rst_done", 32'(cfg_done), 32'h0);
    chk("rst_err", 32'(cfg_err), 32'h0);
    chk("rst_cfg_out", 32'(cfg_out), 32'h0);
    reset_n = 1'b1;
    tick();
    for (int v = 0; v < 1024; v += 73) begin
      le_in = 10'(v);
      #1;
      chk("unconf_sweep", 32'({le_out, cfg_done, cfg_err}), 32'h0);
    end
    le_in = 10'h3ff;
    #1;
    chk("unconf_all1", 32'(le_out), 32'h0);

    // 2: full load, XOR on LE0 combinational, AND5 on LE1 registered
    le_in = '0;
    shift_bits(fv, 66);
    chk("full_done_early", 32'(cfg_done), 32'h0);
    tick();
    chk("full_done", 32'(cfg_done), 32'h1);
    chk("full_err", 32'(cfg_err), 32'h0);
    le_in = {5'b00000, 5'b00111};
    #1;
    chk("xor_00111", 32'(le_out), 32'h1);
    le_in = {5'b00000, 5'b10111};
    #1;
    chk("xor_10111", 32'(le_out), 32'h0);
    le_in = {5'b11111, 5'b00001};
    ce = 1'b1;
    #1;
    chk("and_before_edge", 32'(le_out), 32'h1);
    tick();
    chk("and_registered", 32'(le_out), 32'h3);
    ce = 1'b0;
    le_in = {5'b01111, 5'b00000};
    tick();
    chk("and_hold_ce0", 32'(le_out), 32'h2);

    // 3: short load then recovery with a full load
    shift_bits(fv, 40);
    chk("short_loading_out", 32'(le_out), 32'h0);
    tick();
    chk("short_done", 32'(cfg_done), 32'h0);
    chk("short_err", 32'(cfg_err), 32'h1);
    chk("short_le_out", 32'(le_out), 32'h0);
    shift_bits(fv, 66);
    tick();
    chk("recover_err", 32'(cfg_err), 32'h0);
    chk("recover_done", 32'(cfg_done), 32'h1);

    // 4: over-length load; the first four bits fall out of cfg_out
    for (int i = 0; i < 70; i++) begin
      cfg_en = 1'b1;
      cfg_in = ovr[i];
      tick();
      if (i >= 65 && i <= 68) chk("ovr_cfg_out", 32'(cfg_out), 32'(ovr[i-65]));
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    tick();
    chk("ovr_done", 32'(cfg_done), 32'h1);
    chk("ovr_err", 32'(cfg_err), 32'h0);
    le_in = {5'b11111, 5'b00111};
    #1;
    chk("ovr_le_out", 32'(le_out), 32'h3);
    le_in = {5'b00000, 5'b11111};
    #1;
    chk("ovr_xor_11111", 32'(le_out), 32'h3);

    // 5: async reset in the middle of a load clears everything
    shift_bits(fv, 10);
    tick();
    chk("pre_rst_err", 32'(cfg_err), 32'h1);
    for (int i = 0; i < 30; i++) begin
      cfg_en = 1'b1;
      cfg_in = fv[i];
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_outs", 32'({le_out, cfg_done, cfg_err, cfg_out}), 32'h0);
    cfg_en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk("post_rst_err", 32'(cfg_err), 32'h0);
    chk("post_rst_done", 32'(cfg_done), 32'h0);
    chk("post_rst_le_out", 32'(le_out), 32'h0);

    // 6: reconfigure while ACTIVE, registered LE keeps its q
    le_in = '0;
    shift_bits(fv, 66);
    tick();
    chk("re_done", 32'(cfg_done), 32'h1);
    le_in = {5'b11111, 5'b00000};
    #1;
    chk("re_q_cleared", 32'(le_out), 32'h0);
    ce = 1'b1;
    tick();
    ce = 1'b0;
    chk("re_q_set", 32'(le_out), 32'h2);
    cfg_en = 1'b1;
    cfg_in = fv[0];
    tick();
    chk("re_drop_out", 32'(le_out), 32'h0);
    for (int i = 1; i < 66; i++) begin
      cfg_in = fv[i];
      tick();
      if (i == 33) chk("re_mid_out", 32'(le_out), 32'h0);
    end
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    le_in  = '0;
    #1;
    chk("re_loading_out", 32'(le_out), 32'h0);
    tick();
    chk("re_done2", 32'(cfg_done), 32'h1);
    chk("re_retained_q", 32'(le_out), 32'h2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cfg_logic_cluster.md
Name: cfg_logic_cluster

Overview:
- Parametrised successor to the single 5-input logic tile: a cluster of NUM_LE logic elements, each with a K-input LUT, an output flop and a registered/combinational output select.
- Configuration is loaded through a serial scan chain with a load-tracking state machine, replacing direct writes into tile memory.
- Outputs stay forced to 0 until a complete configuration frame has been shifted in.
- Sits in the fabric wherever logic tiles are instantiated; scan chains of several clusters daisy-chain through cfg_out.

Parameters:
- K, 5, LUT inputs per LE (2..6)
- NUM_LE, 4, logic elements in the cluster (1..16)
- Derived, not overridable: F = 2^K + 1 bits per LE frame; CFG_BITS = NUM_LE*F; CW = clog2(CFG_BITS+1).

Ports:
- clock  input  1  single clock; all flops on posedge
- reset_n  input  1  asynchronous, active-low reset
- cfg_en  input  1  scan enable; one config bit is shifted per cycle while high
- cfg_in  input  1  serial config data in
- cfg_out  output  1  serial config data out (chain bit 0), for daisy-chaining
- ce  input  1  clock enable for the LE output flops
- le_in  input  NUM_LE*K  LE i uses le_in[i*K +: K] as its LUT address
- le_out  output  NUM_LE  LE outputs
- cfg_done  output  1  high while state is ACTIVE
- cfg_err  output  1  sticky flag: the last load was short

Behaviour:
- Reset (async assert, sync release):
  - Chain = all 0, all LE flops q = 0, state = UNCONF, count = 0.
  - le_out = 0, cfg_done = 0, cfg_err = 0, cfg_out = 0.
- Chain shift: each cycle with cfg_en = 1, chain <= {cfg_in, chain[CFG_BITS-1:1]}; cfg_out = chain[0] (registered).
  - The first bit shifted ends at chain[0] after CFG_BITS shifts.
- Frame layout for LE i, base b = i*F:
  - chain[b +: 2^K] = truth table; bit j is the LUT output for address j.
  - chain[b+2^K] = sel: 0 gives combinational output, 1 gives registered output.
- State machine (states UNCONF, LOADING, ACTIVE):
  - Any state, cfg_en = 1: next state = LOADING. Count resets to 1 on entry from UNCONF/ACTIVE, otherwise count <= min(count+1, CFG_BITS) (saturates).
  - LOADING, cfg_en = 0, count == CFG_BITS: next state = ACTIVE, cfg_err <= 0.
  - LOADING, cfg_en = 0, count < CFG_BITS: next state = UNCONF, cfg_err <= 1.
  - cfg_err holds until the next successful load or reset.
- Over-length load: the extra bits keep shifting through, and the last CFG_BITS bits shifted win. Completion is legal and reaches ACTIVE.
- cfg_done = (state == ACTIVE). It rises in the cycle after cfg_en falls on a full load.
- LE datapath:
  - lut_i = chain[b + le_in[i*K +: K]], combinational.
  - q_i <= lut_i on posedge only when state == ACTIVE and ce == 1; otherwise q_i holds.
  - le_out[i] = (state == ACTIVE) ? (sel_i ? q_i : lut_i) : 0.
- Reconfiguration: raising cfg_en in ACTIVE drops le_out to 0 combinationally in the cycle the state leaves ACTIVE. q values are retained, not cleared.
- Reset mid-load: everything returns to reset values and the partial frame is discarded.
- Combinational path le_in -> le_out exists when sel = 0. No combinational path from cfg_in.

Test Plan (K=5, NUM_LE=2, so F=33 and CFG_BITS=66):
1. Reset, then le_in sweep -> le_out = 0, cfg_done = 0, cfg_err = 0 throughout.
2. Full-load XOR test:
   - Stimulus: shift 66 bits. LE0 table = 32'h96696996 (5-input XOR), sel0 = 0; LE1 table = 32'h80000000 (AND5), sel1 = 1. Drop cfg_en.
   - cfg_done = 1 one cycle later.
   - le_in[4:0] = 5'b00111 -> le_out[0] = 1 in the same cycle.
   - le_in[9:5] = 5'b11111 with ce = 1 -> le_out[1] = 1 one cycle later. With ce = 0, le_out[1] holds its prior value.
3. Short load: shift 40 bits, drop cfg_en -> cfg_done = 0, cfg_err = 1, le_out = 0. A following full 66-bit load -> cfg_err = 0, cfg_done = 1.
4. Over-length load:
   - Stimulus: shift 70 bits where the last 66 bits are the case-2 frame.
   - Behaviour is identical to case 2.
   - cfg_out replays the first 4 shifted bits on cycles 67–70 (one-cycle register delay).
5. Async reset mid-load: assert reset_n = 0 at bit 30, between clock edges -> all outputs 0 immediately. After release, the state is UNCONF and cfg_err = 0.
6. Reconfigure while ACTIVE with le_out[1] = 1 registered:
   - Raise cfg_en -> le_out = 2'b00 while loading.
   - Reload with sel1 = 1 and ce = 0 -> le_out[1] = 1 from the retained q as soon as cfg_done rises.
